// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES-128 definitions: forward/inverse S-boxes, round
//                constants, GF(2^8) helpers, key-schedule steps and the
//                controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int NR     = 10;
    localparam int NBYTES = 16;

    // Controller state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_KEXP  = 3'd2;
    localparam logic [2:0] ST_ROUND = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    // S-box tables, entry 0 in the most significant byte
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] c_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Entry x sits at bit offset 8*(255-x), i.e. {~x, 3'b000}
    function automatic logic [7:0] SBOX(input logic [7:0] x);
        return c_SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] INV_SBOX(input logic [7:0] x);
        return c_INV_SBOX[{~x, 3'b000} +: 8];
    endfunction

    // RCON[1:10]; indices outside that range return 0
    function automatic logic [7:0] RCON(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {SBOX(w[31:24]), SBOX(w[23:16]), SBOX(w[15:8]), SBOX(w[7:0])};
    endfunction

    // rk(i-1) -> rk(i); w0 is bits [127:96]
    function automatic logic [127:0] fwdKeyStep(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = subWord({rk[23:0], rk[31:24]}) ^ {rc, 24'h000000};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64]  ^ w0;
        w2 = rk[63:32]  ^ w1;
        w3 = rk[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // rk(i) -> rk(i-1); w3 must be recovered first since w0 depends on it
    function automatic logic [127:0] invKeyStep(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = rk[31:0]  ^ rk[63:32];
        w2 = rk[63:32] ^ rk[95:64];
        w1 = rk[95:64] ^ rk[127:96];
        w0 = rk[127:96] ^ subWord({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_round
//  Description : One combinational AES inverse round:
//                InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
//                (InvMixColumns bypassed when last=1).
//  Ports       : state     in  128  current state (byte 0 = bits [127:120])
//                rk        in  128  round key for this round
//                last      in  1    final round, skip InvMixColumns
//                nextState out 128  resulting state
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] nextState
);

    logic [127:0] w_sub;
    logic [127:0] w_ark;
    logic [127:0] w_mix;

    // Byte i is row i%4 of column i/4; row r is rotated right by r columns,
    // so output (r,c) takes input (r, (c-r) mod 4).
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int c_ROW = i % 4;
        localparam int c_COL = i / 4;
        localparam int c_SRC = 4 * ((c_COL - c_ROW + 4) % 4) + c_ROW;
        assign w_sub[127-8*i -: 8] = INV_SBOX(state[127-8*c_SRC -: 8]);
    end

    assign w_ark = w_sub ^ rk;

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_ark[127-32*c -: 8];
        assign w_a1 = w_ark[119-32*c -: 8];
        assign w_a2 = w_ark[111-32*c -: 8];
        assign w_a3 = w_ark[103-32*c -: 8];
        assign w_mix[127-32*c -: 8] = gmul(w_a0, 8'h0e) ^ gmul(w_a1, 8'h0b) ^ gmul(w_a2, 8'h0d) ^ gmul(w_a3, 8'h09);
        assign w_mix[119-32*c -: 8] = gmul(w_a0, 8'h09) ^ gmul(w_a1, 8'h0e) ^ gmul(w_a2, 8'h0b) ^ gmul(w_a3, 8'h0d);
        assign w_mix[111-32*c -: 8] = gmul(w_a0, 8'h0d) ^ gmul(w_a1, 8'h09) ^ gmul(w_a2, 8'h0e) ^ gmul(w_a3, 8'h0b);
        assign w_mix[103-32*c -: 8] = gmul(w_a0, 8'h0b) ^ gmul(w_a1, 8'h0d) ^ gmul(w_a2, 8'h09) ^ gmul(w_a3, 8'h0e);
    end

    assign nextState = last ? w_ark : w_mix;

endmodule
`default_nettype wire

// File: rtl/aes_decrypt_serial.sv
`default_nettype none
// ============================================================================
//  Module      : aes_decrypt_serial
//  Description : Byte-serial AES-128 decryptor. Key and ciphertext arrive one
//                byte per clock (MSB first), the cipher runs one inverse round
//                per clock with round keys derived on the fly, and plaintext
//                leaves one byte per clock (MSB first).
//  Ports       : clk            in  1  clock, rising edge
//                rst            in  1  asynchronous active-high reset
//                enable         in  1  run/hold qualifier
//                key_byte       in  8  key byte, sampled while load=1
//                state_byte     in  8  ciphertext byte, sampled while load=1
//                state_out_byte out 8  plaintext byte, valid while ready=1
//                load           out 1  an input byte is sampled this cycle
//                ready          out 1  an output byte is presented this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_decrypt_serial
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] key_byte,
    input  logic [7:0] state_byte,
    output logic [7:0] state_out_byte,
    output logic       load,
    output logic       ready
);

    localparam logic [3:0] c_LAST_BYTE = 4'(NBYTES - 1);
    localparam logic [3:0] c_LAST_KEXP = 4'(NR);

    logic [2:0]   r_fsm;
    logic [3:0]   r_byteCnt;
    logic [3:0]   r_round;
    logic [127:0] r_key;
    logic [127:0] r_state;
    logic [127:0] r_roundKey;

    logic [127:0] w_fwdKey;
    logic [127:0] w_invKey;
    logic [127:0] w_roundOut;
    logic         w_lastRound;

    // During KEXP r_round counts 1..10 and selects the forward rcon; during
    // ROUND it counts 9..0 and rk(r+1)->rk(r) needs rcon[r+1].
    assign w_fwdKey    = fwdKeyStep(r_roundKey, RCON(r_round));
    assign w_invKey    = invKeyStep(r_roundKey, RCON(r_round + 4'd1));
    assign w_lastRound = (r_round == 4'd0);

    aes_inv_round u_invRound (
        .state     (r_state),
        .rk        (w_invKey),
        .last      (w_lastRound),
        .nextState (w_roundOut)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm          <= ST_IDLE;
            r_byteCnt      <= 4'd0;
            r_round        <= 4'd0;
            r_key          <= '0;
            r_state        <= '0;
            r_roundKey     <= '0;
            state_out_byte <= 8'h00;
            load           <= 1'b0;
            ready          <= 1'b0;
        end else if (enable) begin
            case (r_fsm)
                ST_IDLE: begin
                    r_fsm     <= ST_LOAD;
                    r_byteCnt <= 4'd0;
                    load      <= 1'b1;
                end
                ST_LOAD: begin
                    r_key   <= {r_key[119:0], key_byte};
                    r_state <= {r_state[119:0], state_byte};
                    if (r_byteCnt == c_LAST_BYTE) begin
                        load       <= 1'b0;
                        r_roundKey <= {r_key[119:0], key_byte};
                        r_round    <= 4'd1;
                        r_fsm      <= ST_KEXP;
                    end else begin
                        r_byteCnt <= r_byteCnt + 4'd1;
                    end
                end
                ST_KEXP: begin
                    r_roundKey <= w_fwdKey;
                    if (r_round == c_LAST_KEXP) begin
                        // rk10 lands now, so the initial AddRoundKey uses it directly
                        r_state <= r_state ^ w_fwdKey;
                        r_round <= 4'd9;
                        r_fsm   <= ST_ROUND;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                ST_ROUND: begin
                    r_roundKey <= w_invKey;
                    r_state    <= w_roundOut;
                    if (w_lastRound) begin
                        ready          <= 1'b1;
                        state_out_byte <= w_roundOut[127:120];
                        r_byteCnt      <= 4'd0;
                        r_fsm          <= ST_OUT;
                    end else begin
                        r_round <= r_round - 4'd1;
                    end
                end
                ST_OUT: begin
                    if (r_byteCnt == c_LAST_BYTE) begin
                        ready <= 1'b0;
                        r_fsm <= ST_IDLE;
                    end else begin
                        // r_state is shifted so the next byte is always at [119:112]
                        state_out_byte <= r_state[119:112];
                        r_state        <= {r_state[119:0], 8'h00};
                        r_byteCnt      <= r_byteCnt + 4'd1;
                    end
                end
                default: begin
                    r_fsm <= ST_IDLE;
                    load  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_decrypt_serial
//  Description : Self-checking bench for aes_decrypt_serial: FIPS-197 vectors,
//                back-to-back blocks, enable stalls, reset mid-round and a
//                round trip against a reference encryption function.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_decrypt_serial;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] key_byte;
    logic [7:0] state_byte;
    logic [7:0] state_out_byte;
    logic       load;
    logic       ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam logic [127:0] c_K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_P2 = 128'h3243f6a8885a308d313198a2e0370734;

    aes_decrypt_serial dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .key_byte       (key_byte),
        .state_byte     (state_byte),
        .state_out_byte (state_out_byte),
        .load           (load),
        .ready          (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encryption, written independently of the decryptor datapath
    function automatic logic [7:0] tbX2(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [127:0] tbEncrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] rk, s, t;
        logic [31:0]  tmp, w0, w1, w2, w3;
        logic [7:0]   rc, a0, a1, a2, a3;
        rk = key;
        s  = pt ^ rk;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            tmp = {SBOX(rk[23:16]), SBOX(rk[15:8]), SBOX(rk[7:0]), SBOX(rk[31:24])} ^ {rc, 24'h0};
            w0  = rk[127:96] ^ tmp;
            w1  = rk[95:64] ^ w0;
            w2  = rk[63:32] ^ w1;
            w3  = rk[31:0] ^ w2;
            rk  = {w0, w1, w2, w3};
            rc  = tbX2(rc);
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[127-8*(4*c+rr) -: 8] = SBOX(s[127-8*(4*((c+rr)%4)+rr) -: 8]);
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127-32*c -: 8];
                    a1 = t[119-32*c -: 8];
                    a2 = t[111-32*c -: 8];
                    a3 = t[103-32*c -: 8];
                    t[127-32*c -: 8] = tbX2(a0) ^ tbX2(a1) ^ a1 ^ a2 ^ a3;
                    t[119-32*c -: 8] = a0 ^ tbX2(a1) ^ tbX2(a2) ^ a2 ^ a3;
                    t[111-32*c -: 8] = a0 ^ a1 ^ tbX2(a2) ^ tbX2(a3) ^ a3;
                    t[103-32*c -: 8] = tbX2(a0) ^ a0 ^ a1 ^ a2 ^ tbX2(a3);
                end
            end
            s = t ^ rk;
        end
        return s;
    endfunction

    // Entered and left at a falling edge. Drives key/ct bytes during load,
    // optionally stalling with junk on the bus once stallAt bytes are sampled.
    task automatic feed(input logic [127:0] key, input logic [127:0] ct, input int stallAt,
                        input int stallLen, output int idleCycles, output int loadCyc);
        int k   = 0;
        int n   = 0;
        int stl = 0;
        idleCycles = 0;
        loadCyc    = -1;
        while (k < 16 && n < 100) begin
            if (load) begin
                check("load_ready_excl", {127'd0, ready}, 128'd0);
                if (loadCyc < 0) loadCyc = cyc;
                if (k == stallAt && stl < stallLen) begin
                    enable     = 1'b0;
                    key_byte   = ~key[127-8*k -: 8];
                    state_byte = ~ct[127-8*k -: 8];
                    stl++;
                end else begin
                    enable     = 1'b1;
                    key_byte   = key[127-8*k -: 8];
                    state_byte = ct[127-8*k -: 8];
                    k++;
                end
            end else begin
                enable = 1'b1;
                if (k == 0) idleCycles++;
            end
            n++;
            @(negedge clk);
        end
        enable = 1'b1;
        check("load_bytes", k, 16);
    endtask

    task automatic collect(input logic [127:0] pt, input int stallAt, input int stallLen,
                           output int readyCyc);
        logic [127:0] got = '0;
        int k   = 0;
        int n   = 0;
        int stl = 0;
        while (!ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        readyCyc = cyc;
        check("ready_rise", {127'd0, ready}, 128'd1);
        while (k < 16) begin
            check("ready_hold", {127'd0, ready}, 128'd1);
            check("out_byte", {120'd0, state_out_byte}, {120'd0, pt[127-8*k -: 8]});
            got[127-8*k -: 8] = state_out_byte;
            if (k == stallAt && stl < stallLen) begin
                enable = 1'b0;
                stl++;
            end else begin
                enable = 1'b1;
                k++;
            end
            @(negedge clk);
        end
        enable = 1'b1;
        check("pt_block", got, pt);
        check("ready_fall", {127'd0, ready}, 128'd0);
        check("out_held", {120'd0, state_out_byte}, {120'd0, pt[7:0]});
    endtask

    initial begin
        int idle, lc, rc;
        logic [127:0] k, p, c;
        rst        = 1'b1;
        enable     = 1'b0;
        key_byte   = 8'h00;
        state_byte = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_load", {127'd0, load}, 128'd0);
        check("rst_ready", {127'd0, ready}, 128'd0);
        check("rst_out", {120'd0, state_out_byte}, 128'd0);
        rst    = 1'b0;
        enable = 1'b1;

        // C.1 with latency measurement, then App.B back to back
        feed(c_K1, c_C1, -1, 0, idle, lc);
        collect(c_P1, -1, 0, rc);
        check("latency", rc - lc, 36);
        feed(c_K2, c_C2, -1, 0, idle, lc);
        check("b2b_idle", idle, 1);
        collect(c_P2, -1, 0, rc);

        // Stalls: 3 cycles after byte 5 of load, 2 cycles at output byte 9
        feed(c_K1, c_C1, 6, 3, idle, lc);
        collect(c_P1, 9, 2, rc);
        check("stall_latency", rc - lc, 39);

        // Reset while r=4 is being processed
        feed(c_K1, c_C1, -1, 0, idle, lc);
        repeat (15) @(negedge clk);
        check("pre_rst_out", {120'd0, state_out_byte}, 128'hff);
        rst = 1'b1;
        #1;
        check("midrst_out", {120'd0, state_out_byte}, 128'd0);
        check("midrst_load", {127'd0, load}, 128'd0);
        check("midrst_ready", {127'd0, ready}, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        feed(c_K1, c_C1, -1, 0, idle, lc);
        collect(c_P1, -1, 0, rc);

        // Round trip through the reference encryptor
        for (int i = 0; i < 20; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            c = tbEncrypt(k, p);
            feed(k, c, -1, 0, idle, lc);
            collect(p, -1, 0, rc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
